// File: rtl/sd_pkg.sv
// Shared SD command-path definitions: FSM state encoding, frame bit constants and widths.
package sd_pkg;

    localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
    localparam logic [1:0] ST_CRC_WAIT_ENC = 2'd1;
    localparam logic [1:0] ST_SHIFT_ENC    = 2'd2;
    localparam logic [1:0] ST_GAP_ENC      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_CRC_WAIT = ST_CRC_WAIT_ENC,
        ST_SHIFT    = ST_SHIFT_ENC,
        ST_GAP      = ST_GAP_ENC
    } cmd_tx_state_t;

    localparam logic SD_START_BIT = 1'b0;
    localparam logic SD_TX_BIT    = 1'b1;
    localparam logic SD_STOP_BIT  = 1'b1;

    localparam int SD_CMD_FRAME_W   = 48;
    localparam int SD_CRC_PAYLOAD_W = 40;
    localparam int SD_CRC7_W        = 7;

    function automatic logic [SD_CRC_PAYLOAD_W-1:0] sd_cmd_payload(
        input logic [5:0]  idx,
        input logic [31:0] arg
    );
        return {SD_START_BIT, SD_TX_BIT, idx, arg};
    endfunction

endpackage

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: payload -> external crc7 -> 48-bit frame shifted out MSB-first.
// Optional N_CC idle gap after the stop bit is enabled by defining SD_CMD_NCC_GAP_EN.
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int CRC_TIMEOUT = 64
`ifdef SD_CMD_NCC_GAP_EN
    ,
    parameter int GAP_BITS = 8
`endif
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [5:0]                  cmd_idx_i,
    input  logic [31:0]                 cmd_arg_i,
    input  logic                        bit_stb_i,
    output logic                        crc_en_o,
    output logic [SD_CRC_PAYLOAD_W-1:0] crc_data_o,
    input  logic [SD_CRC7_W-1:0]        crc_i,
    input  logic                        crc_valid_i,
    output logic                        cmd_o,
    output logic                        cmd_oe_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int              TO_W     = $clog2(CRC_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(CRC_TIMEOUT - 1);
    localparam logic [5:0]      STOP_CNT = 6'(SD_CMD_FRAME_W - 1);
`ifdef SD_CMD_NCC_GAP_EN
    // The gap reuses bit_cnt, which is idle (zero) once the stop bit has gone out.
    localparam logic [5:0]      GAP_LAST = 6'(GAP_BITS - 1);
`endif

    cmd_tx_state_t               state_reg,    state_next;
    logic [SD_CRC_PAYLOAD_W-1:0] crc_data_reg, crc_data_next;
    logic [SD_CMD_FRAME_W-1:0]   shreg_reg,    shreg_next;
    logic [5:0]                  bit_cnt_reg,  bit_cnt_next;
    logic [TO_W-1:0]             to_cnt_reg,   to_cnt_next;
    logic                        oe_reg,       oe_next;
    logic                        crc_en_reg,   crc_en_next;
    logic                        done_reg,     done_next;
    logic                        err_reg,      err_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            crc_data_reg <= '0;
            shreg_reg    <= '1;
            bit_cnt_reg  <= '0;
            to_cnt_reg   <= '0;
            oe_reg       <= 1'b0;
            crc_en_reg   <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            crc_data_reg <= crc_data_next;
            shreg_reg    <= shreg_next;
            bit_cnt_reg  <= bit_cnt_next;
            to_cnt_reg   <= to_cnt_next;
            oe_reg       <= oe_next;
            crc_en_reg   <= crc_en_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        crc_data_next = crc_data_reg;
        shreg_next    = shreg_reg;
        bit_cnt_next  = bit_cnt_reg;
        to_cnt_next   = to_cnt_reg;
        oe_next       = oe_reg;
        crc_en_next   = 1'b0;
        done_next     = 1'b0;
        err_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    crc_data_next = sd_cmd_payload(cmd_idx_i, cmd_arg_i);
                    crc_en_next   = 1'b1;
                    to_cnt_next   = '0;
                    state_next    = ST_CRC_WAIT;
                end
            end

            ST_CRC_WAIT: begin
                if (crc_valid_i) begin
                    shreg_next   = {crc_data_reg, crc_i, SD_STOP_BIT};
                    oe_next      = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = ST_SHIFT;
                end else if (to_cnt_reg >= TO_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (bit_stb_i) begin
                    if (bit_cnt_reg == STOP_CNT) begin
                        // Stop bit has been held a full bit time: release the line high.
                        shreg_next   = '1;
                        oe_next      = 1'b0;
                        bit_cnt_next = '0;
`ifdef SD_CMD_NCC_GAP_EN
                        state_next   = ST_GAP;
`else
                        done_next    = 1'b1;
                        state_next   = ST_IDLE;
`endif
                    end else begin
                        shreg_next   = {shreg_reg[SD_CMD_FRAME_W-2:0], 1'b1};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

`ifdef SD_CMD_NCC_GAP_EN
            ST_GAP: begin
                if (bit_stb_i) begin
                    if (bit_cnt_reg == GAP_LAST) begin
                        bit_cnt_next = '0;
                        done_next    = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
`endif

            default: begin
                shreg_next   = '1;
                oe_next      = 1'b0;
                bit_cnt_next = '0;
                state_next   = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready_o = (state_reg == ST_IDLE);
    assign busy_o      = (state_reg != ST_IDLE);
    assign crc_en_o    = crc_en_reg;
    assign crc_data_o  = crc_data_reg;
    assign cmd_o       = shreg_reg[SD_CMD_FRAME_W-1];
    assign cmd_oe_o    = oe_reg;
    assign done_o      = done_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx with a behavioural crc7 responder and a CMD-line frame monitor.
module tb_sd_cmd_tx;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [5:0]  cmd_idx_i = '0;
    logic [31:0] cmd_arg_i = '0;
    logic        bit_stb_i = 1'b0;
    logic        crc_en_o;
    logic [39:0] crc_data_o;
    logic [6:0]  crc_i = '0;
    logic        crc_valid_i = 1'b0;
    logic        cmd_o;
    logic        cmd_oe_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

`ifdef SD_CMD_NCC_GAP_EN
    localparam int EXP_GAP_STB = 8;
`else
    localparam int EXP_GAP_STB = 0;
`endif

    sd_cmd_tx dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_idx_i   (cmd_idx_i),
        .cmd_arg_i   (cmd_arg_i),
        .bit_stb_i   (bit_stb_i),
        .crc_en_o    (crc_en_o),
        .crc_data_o  (crc_data_o),
        .crc_i       (crc_i),
        .crc_valid_i (crc_valid_i),
        .cmd_o       (cmd_o),
        .cmd_oe_o    (cmd_oe_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    // SD clock enable: one-cycle strobe every 4 clocks.
    initial begin
        int div = 0;
        forever begin
            @(posedge clk_i);
            #1;
            div = (div + 1) % 4;
            bit_stb_i = (div == 0);
        end
    end

    // Behavioural crc7 (x^7 + x^3 + 1), answers 3 cycles after crc_en_o.
    function automatic logic [6:0] crc7_calc(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    bit crc_resp_en = 1'b1;
    initial begin
        int lat = 0;
        forever begin
            @(posedge clk_i);
            #1;
            crc_valid_i = 1'b0;
            if (rst_i) begin
                lat = 0;
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    crc_i       = crc7_calc(crc_data_o);
                    crc_valid_i = 1'b1;
                end
            end else if (crc_en_o && crc_resp_en) begin
                lat = 3;
            end
        end
    end

    // Monitor, sampled on the falling clock edge.
    int          cyc = 0, acc_cnt = 0, done_cnt = 0, err_cnt = 0;
    int          en_cyc = 0, err_cyc = 0, oe_cycles = 0, ready_viol = 0;
    int          stb_total = 0, last_oe_stb = 0, done_stb = 0, oe_stbs = 0, nbits = 0;
    logic [47:0] frame = '0;
    logic [47:0] frames[$];

    always @(negedge clk_i) begin
        cyc++;
        if (rst_i) nbits = 0;
        if (cmd_valid_i && cmd_ready_o) acc_cnt++;
        if (crc_en_o) en_cyc = cyc;
        if (err_o) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (cmd_oe_o) oe_cycles++;
        if (busy_o && cmd_ready_o) ready_viol++;
        if (bit_stb_i) begin
            stb_total++;
            if (cmd_oe_o) begin
                frame = {frame[46:0], cmd_o};
                nbits++;
                oe_stbs++;
                last_oe_stb = stb_total;
                if (nbits == 48) begin
                    frames.push_back(frame);
                    nbits = 0;
                end
            end
        end
        if (done_o) begin
            done_cnt++;
            done_stb = stb_total;
        end
    end

    task automatic wait_accepts(input int target, input string tag);
        int n = 0;
        while (acc_cnt < target && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        if (acc_cnt < target) check({tag, "_accept_timeout"}, 64'(acc_cnt), 64'(target));
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input string tag);
        int a0;
        a0 = acc_cnt;
        @(posedge clk_i);
        #1;
        cmd_idx_i   = idx;
        cmd_arg_i   = arg;
        cmd_valid_i = 1'b1;
        wait_accepts(a0 + 1, tag);
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 600) begin
            @(negedge clk_i);
            n++;
        end
        if (done_cnt < target) check({tag, "_done_timeout"}, 64'(done_cnt), 64'(target));
    endtask

    task automatic check_frame(input int idx, input logic [47:0] exp, input string tag);
        if (frames.size() > idx) check(tag, 64'(frames[idx]), 64'(exp));
        else check({tag, "_missing"}, 64'(frames.size()), 64'(idx + 1));
    endtask

    initial begin
        int d0, e0, o0, s0, f0, r0, a0, n;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_cmd",      64'(cmd_o),       64'd1);
        check("rst_oe",       64'(cmd_oe_o),    64'd0);
        check("rst_ready",    64'(cmd_ready_o), 64'd1);
        check("rst_busy",     64'(busy_o),      64'd0);
        check("rst_crc_en",   64'(crc_en_o),    64'd0);
        check("rst_done_err", 64'({done_o, err_o}), 64'd0);
        check("rst_crc_data", 64'(crc_data_o),  64'd0);
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);

        // 1: CMD0
        d0 = done_cnt; f0 = frames.size();
        send_cmd(6'd0, 32'h0000_0000, "cmd0");
        check("cmd0_crc_data", 64'(crc_data_o), 64'h40_0000_0000);
        wait_done(d0 + 1, "cmd0");
        repeat (60) @(negedge clk_i);
        check_frame(f0, 48'h4000_0000_0095, "cmd0_frame");
        check("cmd0_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("cmd0_gap_strobes", 64'(done_stb - last_oe_stb), 64'(EXP_GAP_STB));
        check("cmd0_idle_line", 64'({cmd_oe_o, cmd_o}), 64'b01);

        // 2: CMD8
        d0 = done_cnt; f0 = frames.size(); s0 = oe_stbs;
        send_cmd(6'd8, 32'h0000_01AA, "cmd8");
        check("cmd8_crc_data", 64'(crc_data_o), 64'h48_0000_01AA);
        wait_done(d0 + 1, "cmd8");
        repeat (60) @(negedge clk_i);
        check_frame(f0, 48'h4800_0001_AA87, "cmd8_frame");
        check("cmd8_oe_strobes", 64'(oe_stbs - s0), 64'd48);
        check("cmd8_gap_strobes", 64'(done_stb - last_oe_stb), 64'(EXP_GAP_STB));

        // 3: back-to-back CMD0 then CMD17 with valid held
        d0 = done_cnt; f0 = frames.size(); r0 = ready_viol; a0 = acc_cnt;
        @(posedge clk_i);
        #1;
        cmd_idx_i = 6'd0; cmd_arg_i = 32'h0; cmd_valid_i = 1'b1;
        wait_accepts(a0 + 1, "b2b_first");
        @(posedge clk_i);
        #1;
        cmd_idx_i = 6'd17; cmd_arg_i = 32'h0;
        check("b2b_ready_low_after_accept", 64'(cmd_ready_o), 64'd0);
        wait_accepts(a0 + 2, "b2b_second");
        check("b2b_first_done_before_second", 64'(done_cnt - d0), 64'd1);
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        wait_done(d0 + 2, "b2b");
        repeat (60) @(negedge clk_i);
        check_frame(f0,     48'h4000_0000_0095, "b2b_frame0");
        check_frame(f0 + 1, 48'h5100_0000_0055, "b2b_frame17");
        check("b2b_ready_while_busy", 64'(ready_viol - r0), 64'd0);
        check("b2b_accepts", 64'(acc_cnt - a0), 64'd2);

        // 4: CRC timeout
        crc_resp_en = 1'b0;
        e0 = err_cnt; o0 = oe_cycles; d0 = done_cnt;
        send_cmd(6'd8, 32'h0000_01AA, "tmo");
        n = 0;
        while (err_cnt == e0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        check("tmo_err_pulses", 64'(err_cnt - e0), 64'd1);
        check("tmo_latency", 64'(err_cyc - en_cyc), 64'd64);
        @(negedge clk_i);
        check("tmo_ready_back", 64'(cmd_ready_o), 64'd1);
        repeat (20) @(negedge clk_i);
        check("tmo_no_oe", 64'(oe_cycles - o0), 64'd0);
        check("tmo_single_err", 64'(err_cnt - e0), 64'd1);
        check("tmo_no_done", 64'(done_cnt - d0), 64'd0);
        crc_resp_en = 1'b1;

        // 5: reset at bit 20 of a CMD8 frame
        d0 = done_cnt; f0 = frames.size();
        send_cmd(6'd8, 32'h0000_01AA, "rstmid");
        n = 0;
        while (nbits < 20 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        check("rstmid_reached_bit20", 64'(nbits), 64'd20);
        #2;
        rst_i = 1'b1;
        #1;
        check("rstmid_oe_released", 64'(cmd_oe_o), 64'd0);
        check("rstmid_cmd_high",    64'(cmd_o),    64'd1);
        check("rstmid_busy",        64'(busy_o),   64'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (250) @(negedge clk_i);
        check("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
        check("rstmid_no_frame", 64'(frames.size() - f0), 64'd0);
        send_cmd(6'd0, 32'h0000_0000, "post_rst");
        wait_done(d0 + 1, "post_rst");
        repeat (60) @(negedge clk_i);
        check_frame(f0, 48'h4000_0000_0095, "post_rst_frame");
        check("post_rst_gap_strobes", 64'(done_stb - last_oe_stb), 64'(EXP_GAP_STB));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
